// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among four matrix cores (a..d).
// Grants one access per cycle while status_i == 2'b01; drains an in-flight read otherwise.
// Optional macro DMEM_ARB_STATS_EN adds a saturating stall counter output (stall_cnt_o).
module dmem_rr_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            status_i,
  input  logic [3:0]            req_i,
  input  logic [3:0]            we_i,
  input  logic [4*ADDR_W-1:0]   addr_i,
  input  logic [4*DATA_W-1:0]   wdata_i,
  output logic [3:0]            gnt_o,
  output logic [3:0]            rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]           stall_cnt_o,
`endif
  output logic                  busy_o
);

  typedef enum logic [1:0] {StIdle, StArb, StDrain} state_e;

  state_e              state_q, state_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [3:0]          rvalid_q, rvalid_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          idx;
  logic                found;

  // Next-state, round-robin search and registered memory-port values.
  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rr_ptr_d    = rr_ptr_q;
    idx         = '0;
    found       = 1'b0;
    // A read issued this cycle returns its data next cycle, whatever the state.
    rvalid_d    = gnt_q & {4{~mem_we_q}};
    unique case (state_q)
      StIdle: begin
        if (status_i == 2'b01) state_d = StArb;
      end
      StArb: begin
        if (status_i != 2'b01) begin
          state_d = (|gnt_q && !mem_we_q) ? StDrain : StIdle;
        end else begin
          for (int k = 0; k < 4; k++) begin
            idx = rr_ptr_q + k[1:0];
            if (!found && req_i[idx]) begin
              found       = 1'b1;
              gnt_d[idx]  = 1'b1;
              mem_en_d    = 1'b1;
              mem_we_d    = we_i[idx];
              mem_addr_d  = addr_i[idx*ADDR_W +: ADDR_W];
              mem_wdata_d = wdata_i[idx*DATA_W +: DATA_W];
              rr_ptr_d    = idx + 2'd1;
            end
          end
        end
      end
      StDrain: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count ARB cycles where some requester is left waiting; restart on each ARB entry.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == StIdle && state_d == StArb) begin
      stall_cnt_d = '0;
    end else if (state_q == StArb && |(req_i & ~gnt_d) && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign gnt_o       = gnt_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = mem_rdata_i;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != StIdle);

endmodule
